// File: rtl/mem_port_arbiter_pkg.sv
// mem_arb_pkg: shared states, op codes, sub-word selects and grant ids for mem_port_arbiter
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;
  typedef enum logic [1:0] {OP_NONE, OP_READ, OP_WRITE} op_t;
  localparam logic [1:0] WSRC_WORD = 2'b00;
  localparam logic [1:0] WSRC_BYTE = 2'b01;
  localparam logic [1:0] WSRC_HALF = 2'b10;
  localparam logic [1:0] WSRC_RSVD = 2'b11;
  localparam logic GRANT_M0 = 1'b0;
  localparam logic GRANT_M1 = 1'b1;
  function automatic op_t decode_op(input logic rd, input logic wr);
    return wr ? OP_WRITE : rd ? OP_READ : OP_NONE;
  endfunction
endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: one requester port; master is the requester, slave is the arbiter
interface mem_port_arbiter_if #(parameter int ADDR_W = 32);
  logic req;
  logic read;
  logic write;
  logic [ADDR_W-1:0] addr;
  logic [31:0] wdata;
  logic [1:0] wsrc;
  logic ack;
  logic [31:0] rdata;
  modport master(output req, read, write, addr, wdata, wsrc, input ack, rdata);
  modport slave(input req, read, write, addr, wdata, wsrc, output ack, rdata);
endinterface

// File: rtl/mem_port_arbiter_pick.sv
// mem_arb_pick: two-requester grant select, round-robin unless MEM_ARB_FIXED_PRIO_EN gives m0 priority
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic req0,
  input  logic req1,
`ifndef MEM_ARB_FIXED_PRIO_EN
  input  logic last_grant,
`endif
  output logic grant_valid,
  output logic grant_id
);
  assign grant_valid = req0 | req1;
`ifdef MEM_ARB_FIXED_PRIO_EN
  assign grant_id = req0 ? GRANT_M0 : GRANT_M1;
`else
  assign grant_id = req0 && req1 ? ~last_grant : req0 ? GRANT_M0 : GRANT_M1;
`endif
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: serialises two requesters onto one async word memory (MEM_ARB_FIXED_PRIO_EN = m0 wins ties)
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int READ_WAIT = 3,
  parameter int ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  mem_port_arbiter_if.slave m0,
  mem_port_arbiter_if.slave m1,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_write_data,
  output logic [1:0]        mem_write_data_src,
  input  logic [31:0]       mem_read_data
);
  localparam int CW = READ_WAIT > 1 ? $clog2(READ_WAIT) : 1;
  state_t state, state_d;
  op_t op;
  logic grant_valid, grant_id, take, cap, gid, gid_d, ack0, ack1;
  logic [CW-1:0] cnt, cnt_d;
  logic [ADDR_W-1:0] addr_d;
  logic [31:0] wdata_d, rdata0, rdata1;
  logic [1:0] wsrc_d;
`ifndef MEM_ARB_FIXED_PRIO_EN
  logic last_grant;
`endif
  mem_arb_pick u_pick (
    .req0       (m0.req),
    .req1       (m1.req),
`ifndef MEM_ARB_FIXED_PRIO_EN
    .last_grant (last_grant),
`endif
    .grant_valid(grant_valid),
    .grant_id   (grant_id)
  );
  assign op   = decode_op(grant_id ? m1.read : m0.read, grant_id ? m1.write : m0.write);
  assign take = state == IDLE && grant_valid;
  assign cap  = state == READ && cnt == '0;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else state <= state_d;
  end
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    state_d = !grant_valid ? IDLE : op == OP_WRITE ? WRITE : op == OP_READ ? READ : RESP;
      READ:    state_d = cap ? RESP : READ;
      WRITE:   state_d = RESP;
      default: state_d = IDLE;
    endcase
  end
  // Request fields are captured only at grant so the memory sees them stable for the whole access.
  always_comb begin
    gid_d   = take ? grant_id : gid;
    addr_d  = take ? (grant_id ? m1.addr : m0.addr) : mem_addr;
    wdata_d = take ? (grant_id ? m1.wdata : m0.wdata) : mem_write_data;
    wsrc_d  = take ? (grant_id ? m1.wsrc : m0.wsrc) : mem_write_data_src;
    cnt_d   = state_d != READ ? '0 : state == READ ? cnt - 1'b1 : CW'(READ_WAIT - 1);
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gid                <= GRANT_M0;
      cnt                <= '0;
      mem_read           <= 1'b0;
      mem_write          <= 1'b0;
      mem_addr           <= '0;
      mem_write_data     <= '0;
      mem_write_data_src <= '0;
      ack0               <= 1'b0;
      ack1               <= 1'b0;
      rdata0             <= '0;
      rdata1             <= '0;
`ifndef MEM_ARB_FIXED_PRIO_EN
      last_grant         <= GRANT_M1;
`endif
    end else begin
      gid                <= gid_d;
      cnt                <= cnt_d;
      mem_read           <= state_d == READ;
      mem_write          <= state_d == WRITE && wsrc_d != WSRC_RSVD;
      mem_addr           <= addr_d;
      mem_write_data     <= wdata_d;
      mem_write_data_src <= wsrc_d;
      ack0               <= state_d == RESP && gid_d == GRANT_M0;
      ack1               <= state_d == RESP && gid_d == GRANT_M1;
      if (cap && gid == GRANT_M0) rdata0 <= mem_read_data;
      if (cap && gid == GRANT_M1) rdata1 <= mem_read_data;
`ifndef MEM_ARB_FIXED_PRIO_EN
      if (take) last_grant <= grant_id;
`endif
    end
  end
  assign m0.ack   = ack0;
  assign m0.rdata = rdata0;
  assign m1.ack   = ack1;
  assign m1.rdata = rdata1;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of mem_port_arbiter against a behavioural async memory
module tb_mem_port_arbiter;
  localparam int RW = 3;
`ifdef MEM_ARB_FIXED_PRIO_EN
  localparam logic [3:0] EXP_SEQ = 4'b0000;
`else
  localparam logic [3:0] EXP_SEQ = 4'b1010;
`endif
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic mem_read, mem_write;
  logic [31:0] mem_addr, mem_write_data, mem_read_data;
  logic [1:0] mem_write_data_src;
  logic [31:0] mem [1024];
  int rd_age = 0;
  int n = 0;
  int errs = 0;
  mem_port_arbiter_if #(.ADDR_W(32)) m0_if ();
  mem_port_arbiter_if #(.ADDR_W(32)) m1_if ();
  mem_port_arbiter #(.READ_WAIT(RW), .ADDR_W(32)) dut (
    .clk(clk), .reset(reset), .m0(m0_if), .m1(m1_if),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_write_data(mem_write_data), .mem_write_data_src(mem_write_data_src),
    .mem_read_data(mem_read_data)
  );
  always #5 clk = ~clk;
  // Memory model: data only valid once mem_read has been held long enough to cover the read delay.
  always @(posedge clk) begin
    rd_age <= mem_read ? rd_age + 1 : 0;
    if (mem_write)
      case (mem_write_data_src)
        2'b00: mem[mem_addr[11:2]] <= mem_write_data;
        2'b01: mem[mem_addr[11:2]][7:0] <= mem_write_data[7:0];
        2'b10: mem[mem_addr[11:2]][15:0] <= mem_write_data[15:0];
        default: ;
      endcase
  end
  assign mem_read_data = (mem_read && rd_age >= RW - 1) ? mem[mem_addr[11:2]] : 32'hBAD0_BAD0;

  task automatic set_port(input bit p, input logic rq, rd, wr, input logic [31:0] a, d, input logic [1:0] s);
    if (!p) begin
      m0_if.req = rq; m0_if.read = rd; m0_if.write = wr; m0_if.addr = a; m0_if.wdata = d; m0_if.wsrc = s;
    end else begin
      m1_if.req = rq; m1_if.read = rd; m1_if.write = wr; m1_if.addr = a; m1_if.wdata = d; m1_if.wsrc = s;
    end
  endtask

  task automatic access(input bit p, input logic rd, wr, input logic [31:0] a, d, input logic [1:0] s,
                        output int lat, output logic [31:0] rdata, output int wrs, output int rds, output int others);
    lat = -1; rdata = 32'h0; wrs = 0; rds = 0; others = 0;
    @(negedge clk);
    set_port(p, 1'b1, rd, wr, a, d, s);
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      wrs += int'(mem_write);
      rds += int'(mem_read);
      others += int'(p ? m0_if.ack : m1_if.ack);
      if (p ? m1_if.ack : m0_if.ack) begin
        lat = i;
        rdata = p ? m1_if.rdata : m0_if.rdata;
        break;
      end
    end
    set_port(p, 1'b0, 1'b0, 1'b0, a, d, s);
  endtask

  task automatic pulse_reset;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset;
    set_port(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00);
    set_port(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    n++; if (mem_read !== 1'b0) begin errs++; $display("FAIL rst_mem_read got %b exp 0", mem_read); end
    n++; if (mem_write !== 1'b0) begin errs++; $display("FAIL rst_mem_write got %b exp 0", mem_write); end
    n++; if (mem_addr !== 32'h0) begin errs++; $display("FAIL rst_mem_addr got %h exp 0", mem_addr); end
    n++; if ({mem_write_data, mem_write_data_src} !== 34'h0) begin errs++; $display("FAIL rst_wdata got %h/%b exp 0", mem_write_data, mem_write_data_src); end
    n++; if ({m0_if.ack, m1_if.ack} !== 2'b00) begin errs++; $display("FAIL rst_acks got %b exp 00", {m0_if.ack, m1_if.ack}); end
    n++; if ({m0_if.rdata, m1_if.rdata} !== 64'h0) begin errs++; $display("FAIL rst_rdata got %h %h exp 0", m0_if.rdata, m1_if.rdata); end
    reset = 1'b1;
  endtask

  task automatic test_write_read;
    int lat, wrs, rds, oth;
    logic [31:0] rd;
    access(1'b1, 1'b0, 1'b1, 32'h010, 32'hDEADBEEF, 2'b00, lat, rd, wrs, rds, oth);
    n++; if (lat !== 2) begin errs++; $display("FAIL wr_latency got %0d exp 2", lat); end
    n++; if (wrs !== 1) begin errs++; $display("FAIL wr_pulses got %0d exp 1", wrs); end
    n++; if (mem[4] !== 32'hDEADBEEF) begin errs++; $display("FAIL wr_mem got %h exp deadbeef", mem[4]); end
    access(1'b0, 1'b1, 1'b0, 32'h010, 32'h0, 2'b00, lat, rd, wrs, rds, oth);
    n++; if (lat !== RW + 1) begin errs++; $display("FAIL rd_latency got %0d exp %0d", lat, RW + 1); end
    n++; if (rd !== 32'hDEADBEEF) begin errs++; $display("FAIL rd_data got %h exp deadbeef", rd); end
    n++; if (rds !== RW || wrs !== 0 || oth !== 0) begin errs++; $display("FAIL rd_strobes got rd=%0d wr=%0d other_ack=%0d exp %0d/0/0", rds, wrs, oth, RW); end
    @(negedge clk);
    n++; if (m0_if.rdata !== 32'hDEADBEEF) begin errs++; $display("FAIL rd_hold got %h exp deadbeef", m0_if.rdata); end
  endtask

  task automatic test_subword;
    int lat, wrs, rds, oth;
    logic [31:0] rd;
    access(1'b1, 1'b0, 1'b1, 32'h010, 32'h11223344, 2'b00, lat, rd, wrs, rds, oth);
    access(1'b0, 1'b0, 1'b1, 32'h010, 32'h000000AB, 2'b01, lat, rd, wrs, rds, oth);
    n++; if (wrs !== 1) begin errs++; $display("FAIL sb_pulses got %0d exp 1", wrs); end
    access(1'b0, 1'b1, 1'b0, 32'h010, 32'h0, 2'b00, lat, rd, wrs, rds, oth);
    n++; if (rd !== 32'h112233AB) begin errs++; $display("FAIL sb_read got %h exp 112233ab", rd); end
    access(1'b0, 1'b0, 1'b1, 32'h010, 32'h0000CAFE, 2'b10, lat, rd, wrs, rds, oth);
    access(1'b1, 1'b1, 1'b0, 32'h010, 32'h0, 2'b00, lat, rd, wrs, rds, oth);
    n++; if (rd !== 32'h1122CAFE) begin errs++; $display("FAIL sh_read got %h exp 1122cafe", rd); end
    n++; if (lat !== RW + 1) begin errs++; $display("FAIL m1_rd_latency got %0d exp %0d", lat, RW + 1); end
  endtask

  task automatic test_reserved_wsrc;
    int lat, wrs, rds, oth;
    logic [31:0] rd;
    access(1'b1, 1'b0, 1'b1, 32'h020, 32'h55AA55AA, 2'b00, lat, rd, wrs, rds, oth);
    access(1'b0, 1'b0, 1'b1, 32'h020, 32'hFFFFFFFF, 2'b11, lat, rd, wrs, rds, oth);
    n++; if (wrs !== 0) begin errs++; $display("FAIL rsvd_pulses got %0d exp 0", wrs); end
    n++; if (lat !== 2) begin errs++; $display("FAIL rsvd_latency got %0d exp 2", lat); end
    access(1'b0, 1'b1, 1'b0, 32'h020, 32'h0, 2'b00, lat, rd, wrs, rds, oth);
    n++; if (rd !== 32'h55AA55AA) begin errs++; $display("FAIL rsvd_read got %h exp 55aa55aa", rd); end
  endtask

  task automatic test_noop;
    int lat, wrs, rds, oth;
    logic [31:0] rd;
    access(1'b1, 1'b0, 1'b0, 32'h030, 32'h12345678, 2'b00, lat, rd, wrs, rds, oth);
    n++; if (lat !== 1) begin errs++; $display("FAIL noop_latency got %0d exp 1", lat); end
    n++; if (wrs !== 0 || rds !== 0) begin errs++; $display("FAIL noop_strobes got wr=%0d rd=%0d exp 0/0", wrs, rds); end
  endtask

  task automatic test_tie;
    logic [3:0] seq = '0;
    int k = 0, first = -1, bad = 0, both = 0;
    pulse_reset();
    @(negedge clk);
    set_port(1'b0, 1'b1, 1'b1, 1'b0, 32'h010, 32'h0, 2'b00);
    set_port(1'b1, 1'b1, 1'b1, 1'b0, 32'h020, 32'h0, 2'b00);
    for (int i = 1; i <= 60 && k < 4; i++) begin
      @(negedge clk);
      if (m0_if.ack || m1_if.ack) begin
        if (k == 0) first = i;
        seq[k[1:0]] = m1_if.ack;
        if (m0_if.ack && m1_if.ack) both++;
        if (m0_if.ack && m0_if.rdata !== 32'h1122CAFE) bad++;
        if (m1_if.ack && m1_if.rdata !== 32'h55AA55AA) bad++;
        k++;
      end
    end
    set_port(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00);
    set_port(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00);
    n++; if (k !== 4) begin errs++; $display("FAIL tie_ack_count got %0d exp 4", k); end
    n++; if (first !== RW + 1) begin errs++; $display("FAIL tie_first_latency got %0d exp %0d", first, RW + 1); end
    n++; if (seq !== EXP_SEQ) begin errs++; $display("FAIL tie_order got %b exp %b (bit i = port of ack i)", seq, EXP_SEQ); end
    n++; if (bad !== 0 || both !== 0) begin errs++; $display("FAIL tie_rdata got bad=%0d dual_ack=%0d exp 0/0", bad, both); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid_read;
    int acks = 0;
    @(negedge clk);
    set_port(1'b0, 1'b1, 1'b1, 1'b0, 32'h020, 32'h0, 2'b00);
    repeat (2) @(negedge clk);
    n++; if (mem_read !== 1'b1) begin errs++; $display("FAIL mid_pre_read got %b exp 1", mem_read); end
    reset = 1'b0;
    set_port(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00);
    #1;
    n++; if (mem_read !== 1'b0 || mem_addr !== 32'h0) begin errs++; $display("FAIL mid_rst_bus got rd=%b addr=%h exp 0/0", mem_read, mem_addr); end
    n++; if (m0_if.rdata !== 32'h0 || m0_if.ack !== 1'b0) begin errs++; $display("FAIL mid_rst_port got rdata=%h ack=%b exp 0/0", m0_if.rdata, m0_if.ack); end
    repeat (3) begin
      @(negedge clk);
      acks += int'(m0_if.ack) + int'(m1_if.ack);
    end
    reset = 1'b1;
    @(negedge clk);
    acks += int'(m0_if.ack) + int'(m1_if.ack);
    n++; if (acks !== 0) begin errs++; $display("FAIL mid_no_ack got %0d acks exp 0", acks); end
    set_port(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00);
    set_port(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00);
    @(negedge clk);
    n++; if ({m0_if.ack, m1_if.ack} !== 2'b10) begin errs++; $display("FAIL mid_first_tie got %b exp 10", {m0_if.ack, m1_if.ack}); end
    set_port(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00);
    set_port(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_subword();
    test_reserved_wsrc();
    test_noop();
    test_tie();
    test_reset_mid_read();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n, errs);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single asynchronous word memory between two requesters.
  - m0 is the multi-cycle CPU.
  - m1 is a loader/debug port used to preload or inspect memory.
- Serialises accesses, holds the memory's read/write/address/data/sub-word-select lines stable for the full access, and returns an ack to the winner.
- Sits between the CPU and the async memory; the CPU's memory pins reconnect to the m0 side.

Parameters:
- READ_WAIT, 3: cycles mem_read is held before read data is sampled. The memory has 7 ns read delay and the clock period is 2.5 ns, so the value must be at least 3.
- ADDR_W, 32: address width, passed through unmodified. The memory uses address[11:2].

Ports:
- clk  in  1  system clock; all state changes on posedge.
- reset  in  1  asynchronous, active-low reset.
- m0_req  in  1  CPU request; held high until m0_ack is seen.
- m0_read  in  1  read request.
- m0_write  in  1  write request.
- m0_addr  in  ADDR_W  byte address.
- m0_wdata  in  32  write data.
- m0_wsrc  in  2  00 word, 01 byte (sb), 10 half (sh), 11 reserved.
- m0_ack  out  1  one-cycle completion pulse.
- m0_rdata  out  32  read data, valid while m0_ack is high.
- m1_req, m1_read, m1_write, m1_addr, m1_wdata, m1_wsrc, m1_ack, m1_rdata: same as m0 for the loader port.
- mem_read  out  1  to memory read.
- mem_write  out  1  to memory write.
- mem_addr  out  ADDR_W  to memory address.
- mem_write_data  out  32  to memory write_data.
- mem_write_data_src  out  2  to memory write_data_src.
- mem_read_data  in  32  from memory read_data.

Behaviour:
- Reset (reset low, asynchronous):
  - state = IDLE.
  - All outputs = 0, including mem_read, mem_write, mem_addr, mem_write_data, mem_write_data_src, both acks and both rdata outputs.
  - Round-robin pointer last_grant = 1, so m0 wins the first tie.
  - Counter = 0.
  - Reset mid-access aborts the access; a write not yet clocked into memory is lost.
- State IDLE:
  - No req high: stay.
  - One req high: grant it.
  - Both high: grant the one not equal to last_grant.
  - On grant, latch grant id, addr, wdata, wsrc and op, and update last_grant.
  - Op decode: write if write=1 (write wins if read and write are both high); else read if read=1; else no-op.
  - Next state: READ, WRITE or RESP (no-op) accordingly.
- State READ:
  - mem_read = 1 and mem_addr = latched addr; counter is loaded with READ_WAIT-1 on entry.
  - When the counter reaches 0, capture mem_read_data into the granted rdata register and go to RESP.
  - Read latency from grant to ack = READ_WAIT+1 cycles.
- State WRITE:
  - One cycle with mem_write = 1 and addr, data and wsrc driven from the latches; the memory commits at the closing posedge. Then go to RESP.
  - If wsrc = 11, mem_write is forced to 0 (nothing written); the ack is still given.
- State RESP:
  - Granted ack = 1 for exactly one cycle; the other ack stays 0.
  - mem_read and mem_write = 0.
  - Next state IDLE.
- Requester rule: drop req (or present a new request) at the posedge that samples ack high. The arbiter never re-grants the same transaction, because IDLE samples req fresh.
- Outputs are registered. mem_addr, mem_write_data and mem_write_data_src hold their last values when idle.
- rdata holds its value until the next read by the same port.
- Starvation bound: with both ports continuously requesting, grants alternate m0, m1, m0, ...

Optional Feature:
- Macro: MEM_ARB_FIXED_PRIO_EN.
- Defined: m0 always wins a tie (CPU priority); last_grant is not used.
- Undefined: round-robin as described above.

Decomposition:
- Package mem_arb_pkg holds:
  - state enum {IDLE, READ, WRITE, RESP};
  - wsrc constants WSRC_WORD=2'b00, WSRC_BYTE=2'b01, WSRC_HALF=2'b10;
  - GRANT_M0 / GRANT_M1 ids.
- One sub-module is natural: mem_arb_pick, combinational two-input grant selection with the round-robin/fixed choice under the macro.

Test Plan:
- m1 write word 0xDEADBEEF to 0x010, then m0 read 0x010: mem_write pulses once; m0_ack is 4 cycles after grant (READ_WAIT=3) with m0_rdata = 0xDEADBEEF.
- m0 sb 0x000000AB (wsrc=01) to 0x010 holding 0x11223344: a subsequent read returns 0x112233AB. sh 0xCAFE (wsrc=10) then gives 0x1122CAFE.
- m0 and m1 request reads on the same cycle after reset: m0 is acked first, then m1. Held continuously, grants alternate. With MEM_ARB_FIXED_PRIO_EN, m0 wins every tie.
- wsrc=11 write of 0xFFFFFFFF to 0x020: mem_write stays 0, the ack is given, and memory at 0x020 is unchanged.
- Assert reset low during READ at wait-count 1: outputs are 0 immediately, no ack is issued, and after release the first tie goes to m0.
- req with read=write=0: ack 1 cycle after grant, mem_read and mem_write never asserted.
